// File: rtl/aes_ctr_sched_if.sv
// Handshake bundle between the AES-CTR frame scheduler and its environment.
// The master modport is the scheduler side; the slave modport is the environment side.
interface aes_ctr_sched_if #(
  parameter int C_CREDIT_W = 8,
  parameter int C_NBLK_W   = 16
);
  logic                  desc_valid;
  logic                  desc_ready;
  logic [95:0]           desc_nonce;
  logic [31:0]           desc_ctr;
  logic [C_NBLK_W-1:0]   desc_nblk;
  logic                  blk_valid;
  logic                  blk_last;
  logic                  blk_ready;
  logic                  ctr_valid;
  logic [127:0]          ctr_block;
  logic                  ctr_last;
  logic                  out_pop;
  logic                  sts_valid;
  logic                  sts_ready;
  logic [31:0]           sts_data;
  logic                  busy;
  logic [C_CREDIT_W-1:0] credit_level;

  modport master (
    input  desc_valid, desc_nonce, desc_ctr, desc_nblk, blk_valid, blk_last, out_pop, sts_ready,
    output desc_ready, blk_ready, ctr_valid, ctr_block, ctr_last, sts_valid, sts_data, busy,
           credit_level
  );

  modport slave (
    output desc_valid, desc_nonce, desc_ctr, desc_nblk, blk_valid, blk_last, out_pop, sts_ready,
    input  desc_ready, blk_ready, ctr_valid, ctr_block, ctr_last, sts_valid, sts_data, busy,
           credit_level
  );
endinterface

// File: rtl/aes_ctr_sched.sv
// Per-frame scheduler for the AES-256 CTR datapath: gates mm2s blocks against output
// FIFO credits, emits one {nonce,ctr} block per accepted data block and one status per frame.
module aes_ctr_sched #(
  parameter int C_CREDITS  = 128,
  parameter int C_CREDIT_W = 8,
  parameter int C_NBLK_W   = 16
) (
  input logic            m_axi_mm2s_aclk,
  input logic            mm2s_prmry_reset,
  aes_ctr_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, STS} state_t;

  localparam logic [C_CREDIT_W-1:0] CREDIT_MAX = C_CREDIT_W'(C_CREDITS);
  localparam logic [C_CREDIT_W-1:0] CREDIT_ONE = C_CREDIT_W'(1);
  localparam logic [C_NBLK_W-1:0]   NBLK_ONE   = C_NBLK_W'(1);

  state_t                state;
  logic [95:0]           nonce;
  logic [31:0]           ctr;
  logic [C_NBLK_W-1:0]   remaining;
  logic [C_NBLK_W-1:0]   issued;
  logic [C_CREDIT_W-1:0] credit;
  logic                  blk_hs;
  logic                  issue;
  logic                  pop_ok;

  function automatic logic [31:0] sts_word(input logic s, input logic l, input logic z,
                                           input logic [C_NBLK_W-1:0] n);
    logic [31:0] w;
    w       = '0;
    w[31]   = s;
    w[30]   = l;
    w[29]   = z;
    w[15:0] = 16'(n);
    return w;
  endfunction

  // blk_ready reacts to credit in the same cycle so a drained FIFO stalls mm2s immediately
  assign bus.desc_ready   = (state == IDLE);
  assign bus.blk_ready    = ((state == RUN) && (credit != '0)) || (state == FLUSH);
  assign bus.busy         = (state != IDLE);
  assign bus.credit_level = credit;

  assign blk_hs = bus.blk_valid && bus.blk_ready;
  assign issue  = blk_hs && (state == RUN);
  // a pop with every credit already home is a protocol violation and is dropped
  assign pop_ok = bus.out_pop && (credit != CREDIT_MAX);

  always_ff @(posedge m_axi_mm2s_aclk) begin
    if (mm2s_prmry_reset) begin
      state         <= IDLE;
      credit        <= CREDIT_MAX;
      nonce         <= '0;
      ctr           <= '0;
      remaining     <= '0;
      issued        <= '0;
      bus.ctr_valid <= 1'b0;
      bus.ctr_block <= '0;
      bus.ctr_last  <= 1'b0;
      bus.sts_valid <= 1'b0;
      bus.sts_data  <= '0;
    end else begin
      bus.ctr_valid <= 1'b0;
      if (issue && !pop_ok)      credit <= credit - CREDIT_ONE;
      else if (!issue && pop_ok) credit <= credit + CREDIT_ONE;

      case (state)
        IDLE: if (bus.desc_valid) begin
          nonce     <= bus.desc_nonce;
          ctr       <= bus.desc_ctr;
          remaining <= bus.desc_nblk;
          issued    <= '0;
          if (bus.desc_nblk == '0) begin
            state         <= STS;
            bus.sts_valid <= 1'b1;
            bus.sts_data  <= sts_word(1'b0, 1'b0, 1'b1, '0);
          end else begin
            state <= RUN;
          end
        end
        RUN: if (issue) begin
          bus.ctr_valid <= 1'b1;
          bus.ctr_block <= {nonce, ctr};
          bus.ctr_last  <= bus.blk_last || (remaining == NBLK_ONE);
          ctr           <= ctr + 32'd1;
          remaining     <= remaining - NBLK_ONE;
          issued        <= issued + NBLK_ONE;
          if (bus.blk_last) begin
            state         <= STS;
            bus.sts_valid <= 1'b1;
            bus.sts_data  <= sts_word(remaining > NBLK_ONE, 1'b0, 1'b0, issued + NBLK_ONE);
          end else if (remaining == NBLK_ONE) begin
            // status word is fixed now; the remaining overlong blocks only get drained
            state        <= FLUSH;
            bus.sts_data <= sts_word(1'b0, 1'b1, 1'b0, issued + NBLK_ONE);
          end
        end
        FLUSH: if (blk_hs && bus.blk_last) begin
          state         <= STS;
          bus.sts_valid <= 1'b1;
        end
        STS: if (bus.sts_ready) begin
          state         <= IDLE;
          bus.sts_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctr_sched.sv
// Directed bench for aes_ctr_sched: frame counters, wrap, credit stall, short/long/empty
// frames and reset mid-frame, with an 8-credit instance.
module tb_aes_ctr_sched;
  localparam int CR  = 8;
  localparam int CRW = 4;
  localparam int NBW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_ctr_sched_if #(.C_CREDIT_W(CRW), .C_NBLK_W(NBW)) bus();

  aes_ctr_sched #(.C_CREDITS(CR), .C_CREDIT_W(CRW), .C_NBLK_W(NBW)) dut (
    .m_axi_mm2s_aclk (clk),
    .mm2s_prmry_reset(rst),
    .bus             (bus.master)
  );

  int checks = 0;
  int errors = 0;

  logic [127:0] cq[$];
  logic         lq[$];
  int  outstanding = 0;
  bit  auto_pop = 1'b0;
  int  pop_req = 0;
  int  pops_done = 0;

  // captures counter blocks and models the output FIFO drain that returns credits
  initial forever begin
    @(negedge clk);
    if (rst) begin
      outstanding = 0;
      bus.out_pop = 1'b0;
    end else begin
      if (bus.out_pop) outstanding--;
      if (bus.ctr_valid) begin
        outstanding++;
        cq.push_back(bus.ctr_block);
        lq.push_back(bus.ctr_last);
      end
      if ((auto_pop || pops_done < pop_req) && outstanding > 0) begin
        bus.out_pop = 1'b1;
        if (!auto_pop) pops_done++;
        if (bus.credit_level == CRW'(CR)) begin
          errors++;
          $display("FAIL pop_at_full credit=%0d required below %0d", bus.credit_level, CR);
        end
      end else begin
        bus.out_pop = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send_desc(input logic [95:0] n, input logic [31:0] c, input logic [NBW-1:0] nb);
    int k;
    bus.desc_valid = 1'b1;
    bus.desc_nonce = n;
    bus.desc_ctr   = c;
    bus.desc_nblk  = nb;
    k = 0;
    while (!bus.desc_ready && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (k >= 50) begin errors++; $display("FAIL desc_timeout waited=%0d limit=50", k); end
    @(negedge clk);
    bus.desc_valid = 1'b0;
  endtask

  task automatic send_blk(input logic last);
    int k;
    bus.blk_valid = 1'b1;
    bus.blk_last  = last;
    k = 0;
    while (!bus.blk_ready && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (k >= 100) begin errors++; $display("FAIL blk_timeout waited=%0d limit=100", k); end
    @(negedge clk);
  endtask

  task automatic wait_sts(output logic [31:0] d);
    int k;
    bus.blk_valid = 1'b0;
    bus.blk_last  = 1'b0;
    k = 0;
    while (!bus.sts_valid && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (k >= 100) begin errors++; $display("FAIL sts_timeout waited=%0d limit=100", k); end
    d = bus.sts_data;
    bus.sts_ready = 1'b1;
    @(negedge clk);
    bus.sts_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (bus.desc_ready !== 1'b1) begin errors++; $display("FAIL rst_desc_ready got=%b exp=1", bus.desc_ready); end
    checks++; if (bus.blk_ready !== 1'b0) begin errors++; $display("FAIL rst_blk_ready got=%b exp=0", bus.blk_ready); end
    checks++; if (bus.ctr_valid !== 1'b0) begin errors++; $display("FAIL rst_ctr_valid got=%b exp=0", bus.ctr_valid); end
    checks++; if (bus.ctr_last !== 1'b0) begin errors++; $display("FAIL rst_ctr_last got=%b exp=0", bus.ctr_last); end
    checks++; if (bus.ctr_block !== 128'h0) begin errors++; $display("FAIL rst_ctr_block got=%h exp=0", bus.ctr_block); end
    checks++; if (bus.sts_valid !== 1'b0) begin errors++; $display("FAIL rst_sts_valid got=%b exp=0", bus.sts_valid); end
    checks++; if (bus.sts_data !== 32'h0) begin errors++; $display("FAIL rst_sts_data got=%h exp=0", bus.sts_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.credit_level !== 4'd8) begin errors++; $display("FAIL rst_credit got=%0d exp=8", bus.credit_level); end
  endtask

  task automatic test_basic();
    logic [95:0]  n;
    logic [31:0]  d;
    logic [127:0] e;
    int base;
    n = {12{8'hA5}};
    base = cq.size();
    send_desc(n, 32'h10, 16'd4);
    for (int i = 0; i < 4; i++) send_blk(i == 3);
    wait_sts(d);
    checks++; if (cq.size() - base !== 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", cq.size() - base); end
    for (int i = 0; i < 4 && base + i < cq.size(); i++) begin
      e = {n, 32'h10 + 32'(i)};
      checks++; if (cq[base+i] !== e) begin errors++; $display("FAIL basic_ctr%0d got=%h exp=%h", i, cq[base+i], e); end
      checks++; if (lq[base+i] !== (i == 3)) begin errors++; $display("FAIL basic_last%0d got=%b exp=%b", i, lq[base+i], i == 3); end
    end
    checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL basic_sts got=%h exp=00000004", d); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_wrap();
    logic [95:0]  n;
    logic [31:0]  d;
    logic [127:0] e [3];
    int base;
    n = 96'h0123_4567_89AB_CDEF_0123_4567;
    e[0] = {n, 32'hFFFF_FFFE};
    e[1] = {n, 32'hFFFF_FFFF};
    e[2] = {n, 32'h0000_0000};
    base = cq.size();
    send_desc(n, 32'hFFFF_FFFE, 16'd3);
    for (int i = 0; i < 3; i++) send_blk(i == 2);
    wait_sts(d);
    checks++; if (cq.size() - base !== 3) begin errors++; $display("FAIL wrap_count got=%0d exp=3", cq.size() - base); end
    for (int i = 0; i < 3 && base + i < cq.size(); i++) begin
      checks++; if (cq[base+i] !== e[i]) begin errors++; $display("FAIL wrap_ctr%0d got=%h exp=%h", i, cq[base+i], e[i]); end
    end
    checks++; if (d !== 32'h0000_0003) begin errors++; $display("FAIL wrap_sts got=%h exp=00000003", d); end
  endtask

  task automatic test_credit();
    logic [31:0] d;
    int base;
    repeat (10) @(negedge clk);
    checks++; if (bus.credit_level !== 4'd8) begin errors++; $display("FAIL credit_home got=%0d exp=8", bus.credit_level); end
    auto_pop = 1'b0;
    base = cq.size();
    send_desc(96'h1, 32'h0, 16'd12);
    bus.blk_valid = 1'b1;
    bus.blk_last  = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (cq.size() - base !== 8) begin errors++; $display("FAIL credit_stall_count got=%0d exp=8", cq.size() - base); end
    checks++; if (bus.blk_ready !== 1'b0) begin errors++; $display("FAIL credit_stall_ready got=%b exp=0", bus.blk_ready); end
    checks++; if (bus.credit_level !== 4'd0) begin errors++; $display("FAIL credit_zero got=%0d exp=0", bus.credit_level); end
    pop_req++;
    repeat (12) @(negedge clk);
    checks++; if (cq.size() - base !== 9) begin errors++; $display("FAIL credit_one_pop got=%0d exp=9", cq.size() - base); end
    checks++; if (bus.blk_ready !== 1'b0) begin errors++; $display("FAIL credit_restall got=%b exp=0", bus.blk_ready); end
    auto_pop = 1'b1;
    for (int i = 0; i < 3; i++) send_blk(i == 2);
    wait_sts(d);
    checks++; if (cq.size() - base !== 12) begin errors++; $display("FAIL credit_total got=%0d exp=12", cq.size() - base); end
    checks++; if (d !== 32'h0000_000C) begin errors++; $display("FAIL credit_sts got=%h exp=0000000c", d); end
  endtask

  task automatic test_short();
    logic [31:0] d;
    int base;
    base = cq.size();
    send_desc(96'h2, 32'h40, 16'd5);
    for (int i = 0; i < 2; i++) send_blk(i == 1);
    wait_sts(d);
    checks++; if (cq.size() - base !== 2) begin errors++; $display("FAIL short_count got=%0d exp=2", cq.size() - base); end
    if (cq.size() - base >= 2) begin
      checks++; if (lq[base] !== 1'b0) begin errors++; $display("FAIL short_last0 got=%b exp=0", lq[base]); end
      checks++; if (lq[base+1] !== 1'b1) begin errors++; $display("FAIL short_last1 got=%b exp=1", lq[base+1]); end
    end
    checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL short_sts got=%h exp=80000002", d); end
  endtask

  task automatic test_long();
    logic [31:0] d;
    int base;
    base = cq.size();
    send_desc(96'h3, 32'h100, 16'd2);
    for (int i = 0; i < 4; i++) send_blk(i == 3);
    wait_sts(d);
    checks++; if (cq.size() - base !== 2) begin errors++; $display("FAIL long_count got=%0d exp=2", cq.size() - base); end
    if (cq.size() - base >= 2) begin
      checks++; if (lq[base+1] !== 1'b1) begin errors++; $display("FAIL long_last got=%b exp=1", lq[base+1]); end
      checks++; if (cq[base+1] !== {96'h3, 32'h101}) begin errors++; $display("FAIL long_ctr1 got=%h exp=%h", cq[base+1], {96'h3, 32'h101}); end
    end
    checks++; if (d !== 32'h4000_0002) begin errors++; $display("FAIL long_sts got=%h exp=40000002", d); end
  endtask

  task automatic test_len0();
    logic [31:0] d;
    int base;
    base = cq.size();
    send_desc(96'h4, 32'h0, 16'd0);
    wait_sts(d);
    checks++; if (cq.size() - base !== 0) begin errors++; $display("FAIL len0_count got=%0d exp=0", cq.size() - base); end
    checks++; if (d !== 32'h2000_0000) begin errors++; $display("FAIL len0_sts got=%h exp=20000000", d); end
  endtask

  task automatic test_reset_mid();
    repeat (10) @(negedge clk);
    auto_pop = 1'b0;
    send_desc(96'h5, 32'h0, 16'd8);
    for (int i = 0; i < 3; i++) send_blk(1'b0);
    bus.blk_valid = 1'b0;
    checks++; if (bus.credit_level !== 4'd5) begin errors++; $display("FAIL mid_credit got=%0d exp=5", bus.credit_level); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.credit_level !== 4'd8) begin errors++; $display("FAIL midrst_credit got=%0d exp=8", bus.credit_level); end
    checks++; if (bus.sts_valid !== 1'b0) begin errors++; $display("FAIL midrst_sts_valid got=%b exp=0", bus.sts_valid); end
    checks++; if (bus.desc_ready !== 1'b1) begin errors++; $display("FAIL midrst_desc_ready got=%b exp=1", bus.desc_ready); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.sts_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_sts got=%b exp=0", bus.sts_valid); end
  endtask

  initial begin
    bus.desc_valid = 1'b0;
    bus.desc_nonce = '0;
    bus.desc_ctr   = '0;
    bus.desc_nblk  = '0;
    bus.blk_valid  = 1'b0;
    bus.blk_last   = 1'b0;
    bus.sts_ready  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    auto_pop = 1'b1;
    @(negedge clk);
    test_basic();
    test_wrap();
    test_credit();
    test_short();
    test_long();
    test_len0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
